// File: rtl/riscv_rsb_ckpt.sv
// rtl/riscv_rsb_ckpt.sv - return stack buffer with single-slot speculative checkpoint/restore
// Circular LIFO of link addresses; oldest entry is overwritten when a push hits a full stack.
module riscv_rsb_ckpt #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned DEPTH    = 4,
   parameter bit          HAS_CKPT = 1'b1
) (
   input  logic                       rst_ni,
   input  logic                       clk_i,
   input  logic                       ena_i,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [XLEN-1:0]            d_i,
   output logic [XLEN-1:0]            q_o,
   output logic                       empty_o,
   output logic                       full_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       ovf_o,
   input  logic                       ckpt_i,
   input  logic                       restore_i
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [XLEN-1:0] entry_q [DEPTH];
   logic [XLEN-1:0] entry_d [DEPTH];
   logic [PW-1:0]   ptr_q, ptr_d, ptr_inc, ptr_dec;
   logic [CW-1:0]   count_q, count_d;
   logic            ovf_q, ovf_d;
   logic [PW-1:0]   s_ptr_q, s_ptr_d;
   logic [CW-1:0]   s_count_q, s_count_d;
   logic [XLEN-1:0] s_top_q, s_top_d;
   logic            is_full, is_empty;

   assign ptr_inc  = ptr_q + 1'b1;
   assign ptr_dec  = ptr_q - 1'b1;
   assign is_full  = (count_q == CW'(DEPTH));
   assign is_empty = (count_q == '0);

   always_comb begin
      entry_d   = entry_q;
      ptr_d     = ptr_q;
      count_d   = count_q;
      ovf_d     = 1'b0;
      s_ptr_d   = s_ptr_q;
      s_count_d = s_count_q;
      s_top_d   = s_top_q;
      if (HAS_CKPT && restore_i) begin
         ptr_d            = s_ptr_q;
         count_d          = s_count_q;
         entry_d[s_ptr_q] = s_top_q;
      end else if (ena_i) begin
         // A simultaneous push/pop replaces the top in place; on empty it degrades to a push.
         if (push_i && pop_i && !is_empty) begin
            entry_d[ptr_q] = d_i;
         end else if (push_i) begin
            ptr_d            = ptr_inc;
            entry_d[ptr_inc] = d_i;
            count_d          = is_full ? count_q : count_q + 1'b1;
            ovf_d            = is_full;
         end else if (pop_i && !is_empty) begin
            ptr_d   = ptr_dec;
            count_d = count_q - 1'b1;
         end
         if (HAS_CKPT && ckpt_i) begin
            s_ptr_d   = ptr_d;
            s_count_d = count_d;
            s_top_d   = entry_d[ptr_d];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
         ptr_q     <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
         s_ptr_q   <= '0;
         s_count_q <= '0;
         s_top_q   <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) entry_q[i] <= entry_d[i];
         ptr_q     <= ptr_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         s_ptr_q   <= s_ptr_d;
         s_count_q <= s_count_d;
         s_top_q   <= s_top_d;
      end
   end

   assign q_o     = is_empty ? '0 : entry_q[ptr_q];
   assign empty_o = is_empty;
   assign full_o  = is_full;
   assign count_o = count_q;
   assign ovf_o   = ovf_q;
endmodule

// File: tb/tb_riscv_rsb_ckpt.sv
// tb/tb_riscv_rsb_ckpt.sv - scoreboard bench for riscv_rsb_ckpt (checkpointing and non-checkpointing builds)
module tb_riscv_rsb_ckpt;
   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        ena_i = 1'b0, push_i = 1'b0, pop_i = 1'b0, ckpt_i = 1'b0, restore_i = 1'b0;
   logic [31:0] d_i = '0;
   logic [31:0] q0, q1;
   logic        e0, e1, f0, f1, o0, o1;
   logic [2:0]  c0, c1;

   always #5 clk_i = ~clk_i;

   riscv_rsb_ckpt #(.XLEN(32), .DEPTH(4), .HAS_CKPT(1'b1)) u_dut (
      .rst_ni(rst_ni), .clk_i(clk_i), .ena_i(ena_i), .push_i(push_i), .pop_i(pop_i),
      .d_i(d_i), .q_o(q0), .empty_o(e0), .full_o(f0), .count_o(c0), .ovf_o(o0),
      .ckpt_i(ckpt_i), .restore_i(restore_i));

   riscv_rsb_ckpt #(.XLEN(32), .DEPTH(4), .HAS_CKPT(1'b0)) u_dut_nc (
      .rst_ni(rst_ni), .clk_i(clk_i), .ena_i(ena_i), .push_i(push_i), .pop_i(pop_i),
      .d_i(d_i), .q_o(q1), .empty_o(e1), .full_o(f1), .count_o(c1), .ovf_o(o1),
      .ckpt_i(ckpt_i), .restore_i(restore_i));

   typedef struct packed {
      logic [31:0] q;
      logic [2:0]  cnt;
      logic        empty;
      logic        full;
      logic        ovf;
   } exp_t;

   typedef struct packed {
      logic [3:0][31:0] e;
      int               ptr;
      int               cnt;
      int               sp;
      int               sc;
      logic [31:0]      st;
   } mdl_t;

   exp_t sb[$];
   mdl_t m[2];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      for (int k = 0; k < 2; k++) m[k] = '0;
   endfunction

   // Reference behaviour: k=0 honours checkpoint/restore, k=1 ignores it.
   function automatic exp_t model_step(int k, bit hc, bit en, bit pu, bit po, logic [31:0] d, bit ck, bit rs);
      exp_t x;
      bit   ovf = 1'b0;
      if (hc && rs) begin
         m[k].ptr = m[k].sp;
         m[k].cnt = m[k].sc;
         m[k].e[m[k].sp] = m[k].st;
      end else if (en) begin
         if (pu && po && m[k].cnt > 0) begin
            m[k].e[m[k].ptr] = d;
         end else if (pu) begin
            ovf = (m[k].cnt == 4);
            m[k].ptr = (m[k].ptr + 1) % 4;
            m[k].e[m[k].ptr] = d;
            if (m[k].cnt < 4) m[k].cnt++;
         end else if (po && m[k].cnt > 0) begin
            m[k].ptr = (m[k].ptr + 3) % 4;
            m[k].cnt--;
         end
         if (hc && ck) begin
            m[k].sp = m[k].ptr;
            m[k].sc = m[k].cnt;
            m[k].st = m[k].e[m[k].ptr];
         end
      end
      x.q     = (m[k].cnt > 0) ? m[k].e[m[k].ptr] : 32'h0;
      x.cnt   = 3'(m[k].cnt);
      x.empty = (m[k].cnt == 0);
      x.full  = (m[k].cnt == 4);
      x.ovf   = ovf;
      return x;
   endfunction

   task automatic step(input bit en, input bit pu, input bit po, input logic [31:0] d,
                       input bit ck, input bit rs, input string tag);
      exp_t x;
      @(negedge clk_i);
      ena_i = en; push_i = pu; pop_i = po; d_i = d; ckpt_i = ck; restore_i = rs;
      sb.push_back(model_step(0, 1'b1, en, pu, po, d, ck, rs));
      sb.push_back(model_step(1, 1'b0, en, pu, po, d, ck, rs));
      @(posedge clk_i);
      #1;
      x = sb.pop_front();
      check({tag, ".q"},     {32'h0, q0}, {32'h0, x.q});
      check({tag, ".cnt"},   {61'h0, c0}, {61'h0, x.cnt});
      check({tag, ".empty"}, {63'h0, e0}, {63'h0, x.empty});
      check({tag, ".full"},  {63'h0, f0}, {63'h0, x.full});
      check({tag, ".ovf"},   {63'h0, o0}, {63'h0, x.ovf});
      x = sb.pop_front();
      check({tag, ".nc.q"},   {32'h0, q1}, {32'h0, x.q});
      check({tag, ".nc.cnt"}, {61'h0, c1}, {61'h0, x.cnt});
      check({tag, ".nc.ovf"}, {63'h0, o1}, {63'h0, x.ovf});
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".q"},     {32'h0, q0}, 64'h0);
      check({tag, ".cnt"},   {61'h0, c0}, 64'h0);
      check({tag, ".empty"}, {63'h0, e0}, 64'h1);
      check({tag, ".full"},  {63'h0, f0}, 64'h0);
      check({tag, ".ovf"},   {63'h0, o0}, 64'h0);
      check({tag, ".nc.cnt"}, {61'h0, c1}, 64'h0);
   endtask

   initial begin
      model_reset();
      repeat (3) @(posedge clk_i);
      #1 check_reset_outputs("reset");
      @(negedge clk_i) rst_ni = 1'b1;

      // basic push/pop
      step(1, 1, 0, 32'h100, 0, 0, "push100");
      step(1, 1, 0, 32'h104, 0, 0, "push104");
      step(1, 1, 0, 32'h108, 0, 0, "push108");
      check("basic.q_top", {32'h0, q0}, 64'h108);
      for (int i = 0; i < 3; i++) step(1, 0, 1, 32'h0, 0, 0, "pop_basic");
      check("basic.empty", {63'h0, e0}, 64'h1);

      // underflow then push
      step(1, 0, 1, 32'h0, 0, 0, "pop_empty");
      step(1, 1, 0, 32'h200, 0, 0, "push200");
      check("uflow.q", {32'h0, q0}, 64'h200);
      step(1, 0, 1, 32'h0, 0, 0, "pop200");

      // overflow with wrap
      for (int i = 1; i <= 5; i++) step(1, 1, 0, 32'(i * 16), 0, 0, "push_ovf");
      check("ovf.pulse", {63'h0, o0}, 64'h1);
      step(1, 0, 1, 32'h0, 0, 0, "pop_after_ovf");
      check("ovf.one_cycle", {63'h0, o0}, 64'h0);
      check("ovf.q", {32'h0, q0}, 64'h40);
      for (int i = 0; i < 4; i++) step(1, 0, 1, 32'h0, 0, 0, "pop_drain");

      // push+pop swap, and on empty
      step(1, 1, 0, 32'h10, 0, 0, "push10");
      step(1, 1, 0, 32'h20, 0, 0, "push20");
      step(1, 1, 1, 32'h99, 0, 0, "swap99");
      check("swap.q", {32'h0, q0}, 64'h99);
      step(1, 0, 1, 32'h0, 0, 0, "pop_swap");
      step(1, 0, 1, 32'h0, 0, 0, "pop_swap");
      step(1, 1, 1, 32'h44, 0, 0, "swap_empty44");
      check("swap_empty.cnt", {61'h0, c0}, 64'h1);
      step(1, 0, 1, 32'h0, 0, 0, "pop44");

      // checkpoint and restore
      step(1, 1, 0, 32'h10, 0, 0, "push10");
      step(1, 1, 0, 32'h20, 0, 0, "push20");
      step(1, 0, 0, 32'h0, 1, 0, "ckpt");
      step(1, 0, 1, 32'h0, 0, 0, "spec_pop");
      step(1, 0, 1, 32'h0, 0, 0, "spec_pop");
      step(1, 1, 0, 32'h77, 0, 0, "spec_push77");
      step(0, 0, 0, 32'h0, 0, 1, "restore");
      check("restore.q", {32'h0, q0}, 64'h20);
      check("restore.cnt", {61'h0, c0}, 64'h2);
      step(1, 0, 1, 32'h0, 0, 0, "pop_restored");

      // ena low holds state; restore with same-cycle push is discarded in favour of restore
      step(0, 1, 0, 32'hDEAD, 0, 0, "ena_low");
      step(1, 1, 0, 32'h30, 1, 0, "push_ckpt30");
      step(1, 1, 0, 32'h31, 0, 0, "push31");
      step(1, 1, 0, 32'h32, 1, 1, "restore_vs_push");
      check("restore_pri.q", {32'h0, q0}, 64'h30);

      // random traffic
      for (int i = 0; i < 60; i++)
         step(1'($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom),
              $urandom, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0), "rand");

      // async reset right after an overflowing push
      for (int i = 0; i < 5; i++) step(1, 1, 0, 32'hA0 + 32'(i), 1, 0, "prefill");
      @(negedge clk_i);
      ena_i = 0; push_i = 0; pop_i = 0; ckpt_i = 0; restore_i = 0;
      #2 rst_ni = 1'b0;
      #1 check_reset_outputs("async_reset");
      model_reset();
      @(negedge clk_i) rst_ni = 1'b1;
      step(0, 0, 0, 32'h0, 0, 1, "restore_after_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running exp finished");
      $fatal(1);
   end
endmodule
